// File: rtl/fxp_div_avg.sv
// fxp_div_avg: sequential signed fixed-point divider and sample averager.
// The result is (Dividend << FB) / Divisor, or the mean of N streamed samples. Start/Ack handshake.
`default_nettype none

module fxp_div_avg #(
    parameter int DW = 16,
    parameter int VW = 8,
    parameter int FB = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Mode,
    input  logic [DW-1:0]      Dividend,
    input  logic [VW-1:0]      Divisor,
    input  logic               SampleValid,
    input  logic [DW-1:0]      SampleData,
    output logic               SampleReady,
    output logic               Busy,
    output logic [DW+FB-1:0]   Quotient,
    output logic [DW-1:0]      Avg,
    output logic               DivZero,
    output logic               Ack
);
    localparam int QW = DW + FB;
    localparam int IW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DIV   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   sum_q, sum_d;
    logic [VW-1:0]   cnt_q, cnt_d;
    logic [VW-1:0]   nv_q, nv_d;
    logic [QW-1:0]   mag_q, mag_d;
    logic [VW-1:0]   rem_q, rem_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic            neg_q, neg_d;
    logic [QW-1:0]   quot_q, quot_d;
    logic            dz_q, dz_d;
    logic            ack_q, ack_d;

    logic [DW-1:0]   w_sum_nxt;
    logic [DW-1:0]   w_src;
    logic [QW-1:0]   w_ext;
    logic [QW-1:0]   w_mag;
    logic [VW:0]     w_rem_sh;
    logic [VW:0]     w_diff;

    assign w_sum_nxt = sum_q + SampleData;
    assign w_src     = (state_q == S_ACCUM) ? w_sum_nxt : Dividend;
    assign w_ext     = {w_src, {FB{1'b0}}};
    // Treated as unsigned, the QW-bit negation of -2^(QW-1) is exactly 2^(QW-1), so the magnitude cannot overflow.
    assign w_mag     = w_src[DW-1] ? (~w_ext + 1'b1) : w_ext;
    assign w_rem_sh  = {rem_q, mag_q[QW-1]};
    assign w_diff    = w_rem_sh - {1'b0, nv_q};

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        nv_d    = nv_q;
        mag_d   = mag_q;
        rem_d   = rem_q;
        iter_d  = iter_q;
        neg_d   = neg_q;
        quot_d  = quot_q;
        dz_d    = dz_q;
        ack_d   = ack_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    ack_d = 1'b0;
                    nv_d  = Divisor;
                    if (Divisor == '0) begin
                        state_d = S_DONE;
                        quot_d  = '1;
                        dz_d    = 1'b1;
                        ack_d   = 1'b1;
                    end else if (Mode) begin
                        state_d = S_ACCUM;
                        sum_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_DIV;
                        mag_d   = w_mag;
                        neg_d   = w_src[DW-1];
                        rem_d   = '0;
                        iter_d  = '0;
                    end
                end
            end
            S_ACCUM: begin
                if (SampleValid) begin
                    sum_d = w_sum_nxt;
                    cnt_d = cnt_q + 1'b1;
                    if ((cnt_q + 1'b1) == nv_q) begin
                        state_d = S_DIV;
                        mag_d   = w_mag;
                        neg_d   = w_src[DW-1];
                        rem_d   = '0;
                        iter_d  = '0;
                    end
                end
            end
            S_DIV: begin
                if (iter_q != IW'(QW)) begin
                    // Restoring step: the dividend shifts out of the top of mag_q while the quotient bits shift in at the bottom.
                    if (!w_diff[VW]) begin
                        rem_d = w_diff[VW-1:0];
                        mag_d = {mag_q[QW-2:0], 1'b1};
                    end else begin
                        rem_d = w_rem_sh[VW-1:0];
                        mag_d = {mag_q[QW-2:0], 1'b0};
                    end
                    iter_d = iter_q + 1'b1;
                end else begin
                    quot_d  = neg_q ? (~mag_q + 1'b1) : mag_q;
                    dz_d    = 1'b0;
                    ack_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            cnt_q   <= '0;
            nv_q    <= '0;
            mag_q   <= '0;
            rem_q   <= '0;
            iter_q  <= '0;
            neg_q   <= 1'b0;
            quot_q  <= '0;
            dz_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            nv_q    <= nv_d;
            mag_q   <= mag_d;
            rem_q   <= rem_d;
            iter_q  <= iter_d;
            neg_q   <= neg_d;
            quot_q  <= quot_d;
            dz_q    <= dz_d;
            ack_q   <= ack_d;
        end
    end

    assign SampleReady = (state_q == S_ACCUM);
    assign Busy        = (state_q == S_ACCUM) || (state_q == S_DIV);
    assign Quotient    = quot_q;
    assign Avg         = quot_q[QW-1:FB];
    assign DivZero     = dz_q;
    assign Ack         = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_fxp_div_avg.sv
// tb_fxp_div_avg: directed, self-checking bench for fxp_div_avg.
// The expected values are worked out by hand for the default widths DW=16, VW=8, FB=8.
`default_nettype none

module tb_fxp_div_avg;
    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Mode;
    logic [15:0] Dividend;
    logic [7:0]  Divisor;
    logic        SampleValid;
    logic [15:0] SampleData;
    logic        SampleReady;
    logic        Busy;
    logic [23:0] Quotient;
    logic [15:0] Avg;
    logic        DivZero;
    logic        Ack;

    int n_chk;
    int n_pass;
    int cyc;
    bit zero_rdy_seen;

    fxp_div_avg #(.DW(16), .VW(8), .FB(8)) u_dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Mode        (Mode),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .SampleValid (SampleValid),
        .SampleData  (SampleData),
        .SampleReady (SampleReady),
        .Busy        (Busy),
        .Quotient    (Quotient),
        .Avg         (Avg),
        .DivZero     (DivZero),
        .Ack         (Ack)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic launch(input logic m, input logic [15:0] dvd, input logic [7:0] dvs);
        Start    = 1'b1;
        Mode     = m;
        Dividend = dvd;
        Divisor  = dvs;
        tick();
        Start    = 1'b0;
    endtask

    task automatic wait_ack(output int c);
        c = 0;
        while (Ack !== 1'b1 && c < 200) begin
            tick();
            c++;
        end
    endtask

    task automatic send(input logic [15:0] d);
        SampleValid = 1'b1;
        SampleData  = d;
        tick();
        SampleValid = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        Reset = 1'b1; Start = 1'b0; Mode = 1'b0; Dividend = '0; Divisor = '0;
        SampleValid = 1'b0; SampleData = '0;
        repeat (3) tick();
        chk("rst_quot", 32'(Quotient), 32'h0);
        chk("rst_avg", 32'(Avg), 32'h0);
        chk("rst_flags", {28'h0, Ack, DivZero, Busy, SampleReady}, 32'h0);
        Reset = 1'b0;
        tick();

        // 12800/25 with the latency counted from the Start edge
        launch(1'b0, 16'h3200, 8'd25);
        chk("div_ack_clr", 32'(Ack), 32'h0);
        chk("div_busy", 32'(Busy), 32'h1);
        wait_ack(cyc);
        chk("div_latency", 32'(cyc), 32'd25);
        chk("div_quot", 32'(Quotient), 32'h020000);
        chk("div_avg", 32'(Avg), 32'h0200);
        chk("div_dz", 32'(DivZero), 32'h0);
        chk("div_busy_done", 32'(Busy), 32'h0);

        // mean of 0x100..0x900, with one idle cycle between samples
        launch(1'b1, 16'h0000, 8'd9);
        chk("avg_ready", 32'(SampleReady), 32'h1);
        for (int i = 1; i <= 9; i++) begin
            send(16'(i * 256));
            if (i < 9) tick();
        end
        chk("avg_ready_drop", 32'(SampleReady), 32'h0);
        chk("avg_busy_div", 32'(Busy), 32'h1);
        wait_ack(cyc);
        chk("avg_ack", 32'(Ack), 32'h1);
        chk("avg_quot", 32'(Quotient), 32'h050000);
        chk("avg_avg", 32'(Avg), 32'h0500);

        // negative operands are truncated toward zero
        launch(1'b0, 16'hFFFF, 8'd3);
        wait_ack(cyc);
        chk("neg1_div3", 32'(Quotient), 32'hFFFFAB);
        launch(1'b0, 16'h8000, 8'd1);
        wait_ack(cyc);
        chk("min_div1", 32'(Quotient), 32'h800000);
        chk("min_avg", 32'(Avg), 32'h8000);

        // a zero divisor finishes at the Start edge
        launch(1'b0, 16'h1234, 8'd0);
        chk("dz0_quot", 32'(Quotient), 32'hFFFFFF);
        chk("dz0_flags", {30'h0, DivZero, Ack}, 32'h3);
        chk("dz0_avg", 32'(Avg), 32'hFFFF);

        launch(1'b0, 16'h0100, 8'd1);
        wait_ack(cyc);
        chk("clr_dz", 32'(DivZero), 32'h0);
        SampleValid = 1'b1;
        SampleData  = 16'h0101;
        launch(1'b1, 16'h0000, 8'd0);
        zero_rdy_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (SampleReady === 1'b1) zero_rdy_seen = 1'b1;
            tick();
        end
        SampleValid = 1'b0;
        chk("dz1_no_ready", 32'(zero_rdy_seen), 32'h0);
        chk("dz1_quot", 32'(Quotient), 32'hFFFFFF);
        chk("dz1_flags", {30'h0, DivZero, Ack}, 32'h3);

        // a Start while the divider is busy has no effect
        launch(1'b0, 16'h3200, 8'd25);
        repeat (5) tick();
        launch(1'b0, 16'h0001, 8'd1);
        chk("ign_busy", 32'(Busy), 32'h1);
        chk("ign_ack", 32'(Ack), 32'h0);
        wait_ack(cyc);
        chk("ign_latency", 32'(cyc + 6), 32'd25);
        chk("ign_quot", 32'(Quotient), 32'h020000);

        // a Reset in the middle of ACCUM abandons the operation
        launch(1'b1, 16'h0000, 8'd4);
        send(16'h0100);
        send(16'h0200);
        Reset = 1'b1;
        tick();
        chk("mid_rst_quot", 32'(Quotient), 32'h0);
        chk("mid_rst_flags", {28'h0, Ack, DivZero, Busy, SampleReady}, 32'h0);
        Reset = 1'b0;
        tick();
        chk("mid_rst_noack", 32'(Ack), 32'h0);
        launch(1'b0, 16'h3200, 8'd25);
        wait_ack(cyc);
        chk("post_rst_lat", 32'(cyc), 32'd25);
        chk("post_rst_quot", 32'(Quotient), 32'h020000);

        // Reset takes priority when it arrives with Start
        Reset = 1'b1;
        launch(1'b0, 16'h3200, 8'd25);
        Reset = 1'b0;
        chk("rst_start_busy", 32'(Busy), 32'h0);
        chk("rst_start_ack", 32'(Ack), 32'h0);

        // the sample sum wraps modulo 2^16
        launch(1'b1, 16'h0000, 8'd2);
        send(16'h7F00);
        send(16'h7F00);
        wait_ack(cyc);
        chk("wrap_quot", 32'(Quotient), 32'hFF0000);
        chk("wrap_avg", 32'(Avg), 32'hFF00);
        tick();
        chk("done_hold", 32'(Quotient), 32'hFF0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
